// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC writeback definitions: data-select encodings and
// architectural constants used by the writeback stage and hazard logic.
package simplerisc_pkg;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'b00,
        WB_SEL_LD  = 2'b01,
        WB_SEL_PC  = 2'b10,
        WB_SEL_ILL = 2'b11
    } wb_sel_e;

    localparam int RA_IDX_DEFAULT = 15;
    localparam int PC_STEP        = 4;

endpackage

// File: rtl/wb_data_sel.sv
// Pure combinational writeback select: picks data and destination from the
// call/load selectors and flags the illegal call+load combination.
module wb_data_sel
    import simplerisc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int RA_IDX = RA_IDX_DEFAULT
) (
    input  logic              is_call_i,
    input  logic              is_ld_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] ld_i,
    input  logic [DATA_W-1:0] pc_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [REG_AW-1:0] waddr_o,
    output logic              illegal_o
);

    wb_sel_e sel;

    assign sel = wb_sel_e'({is_call_i, is_ld_i});

    always_comb begin
        wdata_o   = alu_i;
        illegal_o = 1'b0;
        case (sel)
            WB_SEL_ALU: wdata_o = alu_i;
            WB_SEL_LD:  wdata_o = ld_i;
            WB_SEL_PC:  wdata_o = pc_i + DATA_W'(PC_STEP);
            WB_SEL_ILL: illegal_o = 1'b1;
            default:    illegal_o = 1'b1;
        endcase
    end

    // Calls link into the return-address register regardless of rd.
    assign waddr_o = is_call_i ? REG_AW'(RA_IDX) : rd_i;

endmodule

// File: rtl/writeback_stage_p.sv
// Registered writeback stage: captures the MW bundle, drives the register-file
// write and forwarding ports, and keeps flags, a retire counter and a select error.
module writeback_stage_p
    import simplerisc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int RA_IDX = RA_IDX_DEFAULT,
    parameter int NFLAG  = 1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              hold,
    input  logic              flush,
    input  logic [REG_AW-1:0] rd_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] ld_in,
    input  logic              is_wb_in,
    input  logic              is_ld_in,
    input  logic              is_call_in,
    input  logic              is_set_in,
    input  logic              is_reset_in,
    input  logic [NFLAG-1:0]  flag_mask_in,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fwd_valid,
    output logic [NFLAG-1:0]  flags,
    output logic [CNT_W-1:0]  retired,
    output logic              sel_err
);

    logic              valid_q;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] ld_q;
    logic              isWb_q;
    logic              isLd_q;
    logic              isCall_q;
    logic              isSet_q;
    logic              isReset_q;
    logic [NFLAG-1:0]  mask_q;

    logic [NFLAG-1:0]  flags_q, flags_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              selErr_q, selErr_d;

    logic              capture;
    logic              commit;
    logic              illegal;

    assign capture = in_valid & ~hold & ~flush;
    assign commit  = valid_q & ~flush;

    // Fields are held after a bubble so rf_waddr/rf_wdata keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            rd_q      <= '0;
            pc_q      <= '0;
            alu_q     <= '0;
            ld_q      <= '0;
            isWb_q    <= 1'b0;
            isLd_q    <= 1'b0;
            isCall_q  <= 1'b0;
            isSet_q   <= 1'b0;
            isReset_q <= 1'b0;
            mask_q    <= '0;
            flags_q   <= '0;
            retired_q <= '0;
            selErr_q  <= 1'b0;
        end else begin
            valid_q   <= capture;
            if (capture) begin
                rd_q      <= rd_in;
                pc_q      <= pc_in;
                alu_q     <= alu_in;
                ld_q      <= ld_in;
                isWb_q    <= is_wb_in;
                isLd_q    <= is_ld_in;
                isCall_q  <= is_call_in;
                isSet_q   <= is_set_in;
                isReset_q <= is_reset_in;
                mask_q    <= flag_mask_in;
            end
            flags_q   <= flags_d;
            retired_q <= retired_d;
            selErr_q  <= selErr_d;
        end
    end

    wb_data_sel #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .RA_IDX (RA_IDX)
    ) u_sel (
        .is_call_i (isCall_q),
        .is_ld_i   (isLd_q),
        .rd_i      (rd_q),
        .alu_i     (alu_q),
        .ld_i      (ld_q),
        .pc_i      (pc_q),
        .wdata_o   (rf_wdata),
        .waddr_o   (rf_waddr),
        .illegal_o (illegal)
    );

    // Illegal selects and conflicting set+reset leave flags alone but still retire.
    always_comb begin
        flags_d   = flags_q;
        retired_d = retired_q;
        selErr_d  = selErr_q;
        if (commit) begin
            retired_d = retired_q + 1'b1;
            if (illegal) begin
                selErr_d = 1'b1;
            end else if (isSet_q && isReset_q) begin
                selErr_d = 1'b1;
            end else if (isSet_q) begin
                flags_d = flags_q | mask_q;
            end else if (isReset_q) begin
                flags_d = flags_q & ~mask_q;
            end
        end
    end

    assign rf_we     = commit & isWb_q & ~illegal;
    assign fwd_valid = rf_we;
    assign flags     = flags_q;
    assign retired   = retired_q;
    assign sel_err   = selErr_q;

endmodule

// File: tb/tb_writeback_stage_p.sv
// Directed self-checking bench for writeback_stage_p with NFLAG=2, CNT_W=3.
module tb_writeback_stage_p;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        hold;
    logic        flush;
    logic [3:0]  rd_in;
    logic [31:0] pc_in;
    logic [31:0] alu_in;
    logic [31:0] ld_in;
    logic        is_wb_in;
    logic        is_ld_in;
    logic        is_call_in;
    logic        is_set_in;
    logic        is_reset_in;
    logic [1:0]  flag_mask_in;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [1:0]  flags;
    logic [2:0]  retired;
    logic        sel_err;

    int checkCount = 0;
    int failCount  = 0;

    writeback_stage_p #(
        .DATA_W (32),
        .REG_AW (4),
        .RA_IDX (15),
        .NFLAG  (2),
        .CNT_W  (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .hold         (hold),
        .flush        (flush),
        .rd_in        (rd_in),
        .pc_in        (pc_in),
        .alu_in       (alu_in),
        .ld_in        (ld_in),
        .is_wb_in     (is_wb_in),
        .is_ld_in     (is_ld_in),
        .is_call_in   (is_call_in),
        .is_set_in    (is_set_in),
        .is_reset_in  (is_reset_in),
        .flag_mask_in (flag_mask_in),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .fwd_valid    (fwd_valid),
        .flags        (flags),
        .retired      (retired),
        .sel_err      (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        in_valid     = 1'b0;
        hold         = 1'b0;
        flush        = 1'b0;
        rd_in        = '0;
        pc_in        = '0;
        alu_in       = '0;
        ld_in        = '0;
        is_wb_in     = 1'b0;
        is_ld_in     = 1'b0;
        is_call_in   = 1'b0;
        is_set_in    = 1'b0;
        is_reset_in  = 1'b0;
        flag_mask_in = '0;
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] wrapSeq [9];

    initial begin
        clearInputs();
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        checkOutput("reset rf_we", rf_we, 0);
        checkOutput("reset rf_waddr", rf_waddr, 0);
        checkOutput("reset rf_wdata", rf_wdata, 0);
        checkOutput("reset fwd_valid", fwd_valid, 0);
        checkOutput("reset flags", flags, 0);
        checkOutput("reset retired", retired, 0);
        checkOutput("reset sel_err", sel_err, 0);

        // ALU write to r3
        in_valid = 1'b1; rd_in = 4'd3; alu_in = 32'h1234; is_wb_in = 1'b1;
        applyStimulus();
        clearInputs();
        checkOutput("alu rf_we", rf_we, 1);
        checkOutput("alu rf_waddr", rf_waddr, 3);
        checkOutput("alu rf_wdata", rf_wdata, 32'h1234);
        checkOutput("alu fwd_valid", fwd_valid, 1);
        checkOutput("alu retired pre", retired, 0);
        applyStimulus();
        checkOutput("alu retired post", retired, 1);
        checkOutput("idle rf_we", rf_we, 0);
        checkOutput("idle rf_waddr held", rf_waddr, 3);

        // Call links PC+4 into r15
        in_valid = 1'b1; pc_in = 32'h100; rd_in = 4'd5; is_call_in = 1'b1; is_wb_in = 1'b1;
        applyStimulus();
        clearInputs();
        checkOutput("call rf_we", rf_we, 1);
        checkOutput("call rf_waddr", rf_waddr, 15);
        checkOutput("call rf_wdata", rf_wdata, 32'h104);
        applyStimulus();
        checkOutput("call retired", retired, 2);

        // Load result into r7
        in_valid = 1'b1; rd_in = 4'd7; alu_in = 32'h5; ld_in = 32'hDEADBEEF;
        is_ld_in = 1'b1; is_wb_in = 1'b1;
        applyStimulus();
        clearInputs();
        checkOutput("load rf_we", rf_we, 1);
        checkOutput("load rf_waddr", rf_waddr, 7);
        checkOutput("load rf_wdata", rf_wdata, 32'hDEADBEEF);
        applyStimulus();
        checkOutput("load retired", retired, 3);

        // Hold blocks capture
        in_valid = 1'b1; hold = 1'b1; rd_in = 4'd2; alu_in = 32'h99; is_wb_in = 1'b1;
        applyStimulus();
        clearInputs();
        checkOutput("hold rf_we", rf_we, 0);
        applyStimulus();
        checkOutput("hold retired", retired, 3);

        // Flush kills the captured instruction
        in_valid = 1'b1; rd_in = 4'd4; alu_in = 32'h55; is_wb_in = 1'b1;
        is_set_in = 1'b1; flag_mask_in = 2'b01;
        applyStimulus();
        clearInputs();
        checkOutput("preflush rf_we", rf_we, 1);
        flush = 1'b1;
        #1;
        checkOutput("flush rf_we", rf_we, 0);
        checkOutput("flush fwd_valid", fwd_valid, 0);
        applyStimulus();
        flush = 1'b0;
        checkOutput("flush retired", retired, 3);
        checkOutput("flush flags", flags, 0);

        // Flag set / reset / conflict
        in_valid = 1'b1; is_set_in = 1'b1; flag_mask_in = 2'b11;
        applyStimulus();
        clearInputs();
        applyStimulus();
        checkOutput("set flags", flags, 2'b11);
        checkOutput("set retired", retired, 4);

        in_valid = 1'b1; is_reset_in = 1'b1; flag_mask_in = 2'b01;
        applyStimulus();
        clearInputs();
        applyStimulus();
        checkOutput("reset-mask flags", flags, 2'b10);
        checkOutput("reset-mask sel_err", sel_err, 0);

        in_valid = 1'b1; is_set_in = 1'b1; is_reset_in = 1'b1; flag_mask_in = 2'b11;
        applyStimulus();
        clearInputs();
        applyStimulus();
        checkOutput("conflict flags", flags, 2'b10);
        checkOutput("conflict sel_err", sel_err, 1);
        checkOutput("conflict retired", retired, 6);

        // Illegal call+load: no write, still retires
        in_valid = 1'b1; is_call_in = 1'b1; is_ld_in = 1'b1; is_wb_in = 1'b1;
        is_set_in = 1'b1; flag_mask_in = 2'b01;
        applyStimulus();
        clearInputs();
        checkOutput("illegal rf_we", rf_we, 0);
        checkOutput("illegal fwd_valid", fwd_valid, 0);
        applyStimulus();
        checkOutput("illegal sel_err", sel_err, 1);
        checkOutput("illegal flags", flags, 2'b10);
        checkOutput("illegal retired", retired, 7);
        applyStimulus();
        checkOutput("sticky sel_err", sel_err, 1);

        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkOutput("rst2 sel_err", sel_err, 0);
        checkOutput("rst2 flags", flags, 0);
        checkOutput("rst2 retired", retired, 0);
        checkOutput("rst2 rf_wdata", rf_wdata, 0);

        // Nine back-to-back instructions wrap the 3-bit counter
        wrapSeq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 9);
            applyStimulus();
            if (i >= 1) checkOutput($sformatf("wrap retired %0d", i), retired, wrapSeq[i-1]);
        end
        clearInputs();

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
